ieee488_device: RTL and testbench



---
 rtl/ieee488_pkg.sv | 13 +
 rtl/ieee488_sync.sv | 24 ++
 rtl/ieee488_device.sv | 228 ++++++++++++++++++++++
 tb/tb_ieee488_device.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ieee488_pkg.sv
// Shared types and command constants for the IEEE-488 device-side interface.
package ieee488_pkg;

    typedef enum logic [2:0] {AIDS, ANRS, ACRS, ACDS, AWNS} ah_state_t;
    typedef enum logic [2:0] {SIDS, SGNS, SDYS, STRS, SWNS} sh_state_t;

    localparam logic [7:0] CMD_LAD = 8'h20;
    localparam logic [7:0] CMD_UNL = 8'h3F;
    localparam logic [7:0] CMD_TAD = 8'h40;
    localparam logic [7:0] CMD_UNT = 8'h5F;
    localparam logic [7:0] CMD_SAD = 8'h60;

endpackage

// File: rtl/ieee488_sync.sv
// Two-flop synchronizer; resets to the released (all-ones) level so no false edges follow reset.
module ieee488_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/ieee488_device.sv
// IEEE-488 peripheral: acceptor (AH) and source (SH) handshakes plus LISTEN/TALK decode.
// Optional watchdog on stalled handshakes is built when IEEE488_TIMEOUT_EN is defined.
module ieee488_device
    import ieee488_pkg::*;
#(
    parameter logic [4:0] DEV_ADDR       = 5'd8,
    parameter int         T1_CYCLES      = 64,
    parameter int         TIMEOUT_CYCLES = 32000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       atn_i,
    input  logic       dav_i,
    input  logic       eoi_i,
    input  logic       nrfd_i,
    input  logic       ndac_i,
    input  logic       ifc_i,
    input  logic [7:0] data_i,
    output logic       dav_o,
    output logic       eoi_o,
    output logic       nrfd_o,
    output logic       ndac_o,
    output logic [7:0] data_o,
    output logic [7:0] rx_data,
    output logic       rx_eoi,
    output logic       rx_atn,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       listen,
    output logic       talk
);
    localparam logic [7:0]  MY_LAD  = CMD_LAD | {3'b000, DEV_ADDR};
    localparam logic [7:0]  MY_TAD  = CMD_TAD | {3'b000, DEV_ADDR};
    localparam logic [15:0] T1_LAST = 16'(T1_CYCLES - 1);

    logic       atn_s, dav_s, eoi_s, nrfd_s, ndac_s, ifc_s;
    logic [7:0] data_s;

    ieee488_sync #(.WIDTH(14)) u_sync (
        .clk_i   (clk_sys),
        .reset_i (reset),
        .d_i     ({atn_i, dav_i, eoi_i, nrfd_i, ndac_i, ifc_i, data_i}),
        .q_o     ({atn_s, dav_s, eoi_s, nrfd_s, ndac_s, ifc_s, data_s})
    );

    ah_state_t  ah_q, ah_d;
    sh_state_t  sh_q, sh_d;
    logic       atn_prev_q, listen_q, talk_q, rx_valid_q;
    logic       nrfd_q, ndac_q, dav_q, eoi_q, tx_ready_q, tx_done_q, tx_err_q;
    logic [7:0] data_o_q, rx_data_q, tx_byte_q;
    logic       rx_eoi_q, rx_atn_q, tx_eoi_q;
    logic [15:0] t1_cnt_q;
    logic       ah_to, sh_to;

    logic       atn_fall, ah_active, ah_push, t1_done, tx_load, sh_drive;
    logic [7:0] rx_byte, tx_cur;
    logic       tx_cur_eoi;

    assign atn_fall  = atn_prev_q & ~atn_s;
    assign ah_active = listen_q | ~atn_s;
    assign rx_byte   = ~data_s;
    // Secondary addresses reach the consumer only while addressed; other ATN bytes are dropped.
    assign ah_push   = ifc_s && (ah_q == ACDS) &&
                       (atn_s ? listen_q : ((rx_byte[7:5] == CMD_SAD[7:5]) && (listen_q || talk_q)));

    always_comb begin
        ah_d = ah_q;
        if (!ifc_s)
            ah_d = AIDS;
        else if (atn_fall || ah_to)
            ah_d = ANRS;
        else begin
            case (ah_q)
                AIDS: if (ah_active) ah_d = ANRS;
                ANRS: if (!ah_active) ah_d = AIDS; else if (!rx_valid_q) ah_d = ACRS;
                ACRS: if (!ah_active) ah_d = AIDS; else if (!dav_s) ah_d = ACDS;
                ACDS: ah_d = AWNS;
                AWNS: if (dav_s) ah_d = ah_active ? ANRS : AIDS;
                default: ah_d = AIDS;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ah_q       <= AIDS;
            nrfd_q     <= 1'b1;
            ndac_q     <= 1'b1;
            listen_q   <= 1'b0;
            talk_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            atn_prev_q <= 1'b1;
        end else begin
            ah_q       <= ah_d;
            nrfd_q     <= !(ah_d inside {ANRS, ACDS, AWNS});
            ndac_q     <= !(ah_d inside {ANRS, ACRS, ACDS});
            atn_prev_q <= atn_s;
            if (ah_push)
                rx_valid_q <= 1'b1;
            else if (rx_valid_q && rx_ready)
                rx_valid_q <= 1'b0;
            if (!ifc_s) begin
                listen_q <= 1'b0;
                talk_q   <= 1'b0;
            end else if (ah_q == ACDS && !atn_s) begin
                if (rx_byte == MY_LAD) begin
                    listen_q <= 1'b1;
                    talk_q   <= 1'b0;
                end else if (rx_byte == CMD_UNL) begin
                    listen_q <= 1'b0;
                end else if (rx_byte == MY_TAD) begin
                    talk_q   <= 1'b1;
                    listen_q <= 1'b0;
                end else if (rx_byte[7:5] == CMD_UNT[7:5]) begin
                    talk_q   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (ah_push) begin
            rx_data_q <= rx_byte;
            rx_eoi_q  <= ~eoi_s;
            rx_atn_q  <= ~atn_s;
        end
    end

    assign t1_done    = (t1_cnt_q == T1_LAST);
    assign tx_load    = (sh_q == SGNS) && tx_valid && tx_ready_q;
    assign tx_cur     = tx_load ? tx_data : tx_byte_q;
    assign tx_cur_eoi = tx_load ? tx_eoi : tx_eoi_q;

    always_comb begin
        sh_d = sh_q;
        if (!ifc_s || !talk_q || !atn_s)
            sh_d = SIDS;
        else if (sh_to)
            sh_d = SGNS;
        else begin
            case (sh_q)
                SIDS: sh_d = SGNS;
                SGNS: if (tx_load) sh_d = SDYS;
                SDYS: if (t1_done) begin
                          if (nrfd_s && ndac_s) sh_d = SGNS;
                          else if (nrfd_s)      sh_d = STRS;
                      end
                STRS: if (ndac_s)  sh_d = SWNS;
                SWNS: if (!ndac_s) sh_d = SGNS;
                default: sh_d = SIDS;
            endcase
        end
    end

    assign sh_drive = (sh_d == SDYS) || (sh_d == STRS);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sh_q       <= SIDS;
            dav_q      <= 1'b1;
            eoi_q      <= 1'b1;
            data_o_q   <= 8'hFF;
            tx_ready_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            t1_cnt_q   <= '0;
        end else begin
            sh_q       <= sh_d;
            dav_q      <= (sh_d != STRS);
            eoi_q      <= sh_drive ? ~tx_cur_eoi : 1'b1;
            data_o_q   <= sh_drive ? ~tx_cur : 8'hFF;
            tx_ready_q <= (sh_d == SGNS);
            tx_done_q  <= (sh_q == STRS) && (sh_d == SWNS);
            tx_err_q   <= (sh_d == SGNS) && ((sh_q == SDYS) || sh_to);
            // Count saturates at T1_LAST so SDYS can keep waiting for NRFD.
            t1_cnt_q   <= (sh_q == SDYS && sh_d == SDYS) ? (t1_done ? t1_cnt_q : t1_cnt_q + 16'd1) : '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (tx_load) begin
            tx_byte_q <= tx_data;
            tx_eoi_q  <= tx_eoi;
        end
    end

`ifdef IEEE488_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] ah_wd_q, sh_wd_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ah_wd_q <= '0;
            sh_wd_q <= '0;
        end else begin
            ah_wd_q <= (ah_d != ah_q || !(ah_q inside {ACRS, AWNS})) ? '0 : ah_wd_q + 16'd1;
            sh_wd_q <= (sh_d != sh_q || !(sh_q inside {STRS, SWNS})) ? '0 : sh_wd_q + 16'd1;
        end
    end

    assign ah_to = (ah_q inside {ACRS, AWNS}) && (ah_wd_q == TO_LAST);
    assign sh_to = (sh_q inside {STRS, SWNS}) && (sh_wd_q == TO_LAST);
`else
    assign ah_to = 1'b0;
    assign sh_to = 1'b0;
`endif

    assign nrfd_o   = nrfd_q;
    assign ndac_o   = ndac_q;
    assign dav_o    = dav_q;
    assign eoi_o    = eoi_q;
    assign data_o   = data_o_q;
    assign rx_data  = rx_data_q;
    assign rx_eoi   = rx_eoi_q;
    assign rx_atn   = rx_atn_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;
    assign listen   = listen_q;
    assign talk     = talk_q;
endmodule

// File: tb/tb_ieee488_device.sv
// Directed bench for ieee488_device: the bench plays the host controller and, for talk tests, the listener.
module tb_ieee488_device;
    localparam int T1 = 64;
    localparam int TO = 32000;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       atn_i, dav_i, eoi_i, nrfd_i, ndac_i, ifc_i;
    logic [7:0] data_i;
    logic       dav_o, eoi_o, nrfd_o, ndac_o;
    logic [7:0] data_o;
    logic [7:0] rx_data;
    logic       rx_eoi, rx_atn, rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_eoi, tx_valid, tx_ready, tx_done, tx_err, listen, talk;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    ieee488_device #(.DEV_ADDR(5'd8), .T1_CYCLES(T1), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .atn_i(atn_i), .dav_i(dav_i), .eoi_i(eoi_i), .nrfd_i(nrfd_i), .ndac_i(ndac_i), .ifc_i(ifc_i),
        .data_i(data_i), .dav_o(dav_o), .eoi_o(eoi_o), .nrfd_o(nrfd_o), .ndac_o(ndac_o), .data_o(data_o),
        .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_atn(rx_atn), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_eoi(tx_eoi), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_err(tx_err), .listen(listen), .talk(talk)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // sel: 0 nrfd_o, 1 ndac_o, 2 dav_o, 3 tx_ready
    task automatic wait_line(input int sel, input logic val, input int budget, input string tag);
        int   n;
        logic cur;
        n = 0;
        checks++;
        while (1) begin
            case (sel)
                0:       cur = nrfd_o;
                1:       cur = ndac_o;
                2:       cur = dav_o;
                default: cur = tx_ready;
            endcase
            if (cur === val) break;
            if (n >= budget) begin
                errors++;
                $display("FAIL wait_%s: line=%b after %0d cycles, required %b", tag, cur, n, val);
                break;
            end
            @(negedge clk_sys);
            n++;
        end
    endtask

    task automatic host_send(input logic [7:0] b, input logic eoi);
        wait_line(0, 1'b1, 50, "host_nrfd");
        data_i = ~b;
        eoi_i  = ~eoi;
        tick(1);
        dav_i = 1'b0;
        wait_line(1, 1'b1, 50, "host_ndac");
        checks++;
        if (nrfd_o !== 1'b0) begin errors++; $display("FAIL awns_nrfd: nrfd_o=%b required 0", nrfd_o); end
        dav_i  = 1'b1;
        data_i = 8'hFF;
        eoi_i  = 1'b1;
        tick(4);
    endtask

    task automatic pop_rx;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        atn_i = 1'b1; dav_i = 1'b1; eoi_i = 1'b1; nrfd_i = 1'b1; ndac_i = 1'b1; ifc_i = 1'b1;
        data_i = 8'hFF; rx_ready = 1'b0; tx_data = 8'h00; tx_eoi = 1'b0; tx_valid = 1'b0;
        tick(3);
        checks++; if ({dav_o, eoi_o, nrfd_o, ndac_o} !== 4'b1111) begin errors++; $display("FAIL rst_lines: got %b required 1111", {dav_o, eoi_o, nrfd_o, ndac_o}); end
        checks++; if (data_o !== 8'hFF) begin errors++; $display("FAIL rst_data_o: got %h required ff", data_o); end
        checks++; if ({listen, talk} !== 2'b00) begin errors++; $display("FAIL rst_addr: got %b required 00", {listen, talk}); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
        checks++; if ({tx_ready, tx_done, tx_err} !== 3'b000) begin errors++; $display("FAIL rst_tx: got %b required 000", {tx_ready, tx_done, tx_err}); end
        reset = 1'b0;
        tick(4);
        checks++; if ({nrfd_o, ndac_o} !== 2'b11) begin errors++; $display("FAIL idle_aids: got %b required 11", {nrfd_o, ndac_o}); end
    endtask

    task automatic test_listen;
        atn_i = 1'b0;
        tick(5);
        host_send(8'h28, 1'b0);
        checks++; if (listen !== 1'b1) begin errors++; $display("FAIL lad_listen: got %b required 1", listen); end
        host_send(8'h62, 1'b0);
        checks++; if ({rx_valid, rx_atn, rx_data} !== {2'b11, 8'h62}) begin errors++; $display("FAIL sad_push: got v=%b atn=%b d=%h required 1 1 62", rx_valid, rx_atn, rx_data); end
        pop_rx();
        atn_i = 1'b1;
        tick(5);
        host_send(8'h41, 1'b1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL data_valid: got %b required 1", rx_valid); end
        checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL data_byte: got %h required 41", rx_data); end
        checks++; if ({rx_eoi, rx_atn} !== 2'b10) begin errors++; $display("FAIL data_flags: got eoi=%b atn=%b required 1 0", rx_eoi, rx_atn); end
        checks++; if ({listen, talk} !== 2'b10) begin errors++; $display("FAIL data_addr: got %b required 10", {listen, talk}); end
    endtask

    task automatic test_backpressure;
        logic held;
        held = 1'b1;
        data_i = ~8'h99;
        for (int i = 0; i < 20; i++) begin
            if (nrfd_o !== 1'b0 || ndac_o !== 1'b0) held = 1'b0;
            tick(1);
        end
        data_i = 8'hFF;
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL bp_anrs: nrfd/ndac released while full, required held 0"); end
        checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL bp_keep: got %h required 41", rx_data); end
        pop_rx();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL bp_pop: got %b required 0", rx_valid); end
        host_send(8'h99, 1'b0);
        checks++; if ({rx_valid, rx_eoi, rx_data} !== {2'b10, 8'h99}) begin errors++; $display("FAIL bp_second: got v=%b eoi=%b d=%h required 1 0 99", rx_valid, rx_eoi, rx_data); end
        pop_rx();
        tick(10);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got %b required 0", rx_valid); end
    endtask

    task automatic test_talk;
        int cnt, dones;
        nrfd_i = 1'b1; ndac_i = 1'b0;
        atn_i = 1'b0;
        tick(5);
        host_send(8'h48, 1'b0);
        atn_i = 1'b1;
        wait_line(3, 1'b1, 20, "talk_ready");
        checks++; if ({listen, talk} !== 2'b01) begin errors++; $display("FAIL tad_addr: got %b required 01", {listen, talk}); end
        tx_data = 8'h55; tx_eoi = 1'b1; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        cnt = 0;
        while (dav_o === 1'b1 && cnt < 200) begin tick(1); cnt++; end
        checks++; if (cnt < T1 || cnt > T1 + 4) begin errors++; $display("FAIL t1_delay: DAV low after %0d cycles required %0d..%0d", cnt, T1, T1 + 4); end
        checks++; if (data_o !== 8'hAA) begin errors++; $display("FAIL talk_data: got %h required aa", data_o); end
        checks++; if (eoi_o !== 1'b0) begin errors++; $display("FAIL talk_eoi: got %b required 0", eoi_o); end
        nrfd_i = 1'b0; ndac_i = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (tx_done === 1'b1) dones++; end
        checks++; if (dones != 1) begin errors++; $display("FAIL tx_done_once: pulses=%0d required 1", dones); end
        checks++; if ({dav_o, eoi_o, data_o} !== {2'b11, 8'hFF}) begin errors++; $display("FAIL talk_release: got dav=%b eoi=%b d=%h required 1 1 ff", dav_o, eoi_o, data_o); end
        ndac_i = 1'b0;
        tick(5);
        nrfd_i = 1'b1;
        wait_line(3, 1'b1, 20, "talk_again");
    endtask

    task automatic test_no_listener;
        int errs, err_at, dav_low;
        nrfd_i = 1'b1; ndac_i = 1'b1;
        tx_data = 8'h12; tx_eoi = 1'b0; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        errs = 0; err_at = -1; dav_low = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (dav_o !== 1'b1) dav_low++;
            if (tx_err === 1'b1) begin errs++; if (err_at < 0) err_at = i; end
        end
        checks++; if (dav_low != 0) begin errors++; $display("FAIL nl_dav: DAV low for %0d cycles required 0", dav_low); end
        checks++; if (errs != 1) begin errors++; $display("FAIL nl_err_count: pulses=%0d required 1", errs); end
        checks++; if (err_at < T1) begin errors++; $display("FAIL nl_err_time: pulse at %0d required >= %0d", err_at, T1); end
        checks++; if ({tx_ready, data_o} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL nl_back: got ready=%b d=%h required 1 ff", tx_ready, data_o); end
    endtask

    task automatic test_atn_abort;
        int n;
        nrfd_i = 1'b1; ndac_i = 1'b0;
        tx_data = 8'h33; tx_eoi = 1'b1; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        wait_line(2, 1'b0, 100, "strs_dav");
        atn_i = 1'b0;
        n = 0;
        while (!(dav_o === 1'b1 && eoi_o === 1'b1 && data_o === 8'hFF) && n < 20) begin tick(1); n++; end
        checks++; if (n > 3) begin errors++; $display("FAIL atn_release: bus released after %0d cycles required <= 3", n); end
        tick(3);
        host_send(8'h5F, 1'b0);
        checks++; if (talk !== 1'b0) begin errors++; $display("FAIL unt_talk: got %b required 0", talk); end
        atn_i = 1'b1;
        tick(5);
        checks++; if ({tx_ready, dav_o} !== 2'b01) begin errors++; $display("FAIL unt_sids: got ready=%b dav=%b required 0 1", tx_ready, dav_o); end
        nrfd_i = 1'b1; ndac_i = 1'b1;
    endtask

    task automatic test_ifc;
        atn_i = 1'b0;
        tick(5);
        host_send(8'h28, 1'b0);
        atn_i = 1'b1;
        tick(5);
        host_send(8'hC3, 1'b0);
        checks++; if ({listen, rx_valid} !== 2'b11) begin errors++; $display("FAIL ifc_pre: got listen=%b v=%b required 1 1", listen, rx_valid); end
        ifc_i = 1'b0;
        tick(2);
        ifc_i = 1'b1;
        tick(4);
        checks++; if (listen !== 1'b0) begin errors++; $display("FAIL ifc_listen: got %b required 0", listen); end
        checks++; if ({nrfd_o, ndac_o} !== 2'b11) begin errors++; $display("FAIL ifc_lines: got %b required 11", {nrfd_o, ndac_o}); end
        checks++; if ({rx_valid, rx_data} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL ifc_rx_keep: got v=%b d=%h required 1 c3", rx_valid, rx_data); end
        pop_rx();
    endtask

`ifdef IEEE488_TIMEOUT_EN
    task automatic test_timeout;
        int cnt;
        atn_i = 1'b0;
        tick(5);
        host_send(8'h28, 1'b0);
        atn_i = 1'b1;
        wait_line(0, 1'b1, 50, "to_nrfd");
        data_i = 8'hFF;
        tick(1);
        dav_i = 1'b0;
        wait_line(1, 1'b1, 50, "to_ndac");
        cnt = 0;
        while (ndac_o === 1'b1 && cnt < 40000) begin tick(1); cnt++; end
        checks++; if (cnt < TO - 2 || cnt > TO + 4) begin errors++; $display("FAIL ah_timeout: abort after %0d cycles required about %0d", cnt, TO); end
        checks++; if ({nrfd_o, ndac_o} !== 2'b00) begin errors++; $display("FAIL ah_to_anrs: got %b required 00", {nrfd_o, ndac_o}); end
        dav_i = 1'b1;
        pop_rx();
        tick(5);
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_listen();
        test_backpressure();
        test_talk();
        test_no_listener();
        test_atn_abort();
        test_ifc();
`ifdef IEEE488_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
